// File: rtl/game_cmd_encoder.sv
// Pushbutton front end: synchronise, debounce and edge-detect start/pause/quit into {C,D,E} codes.
// Optional build macro CMD_HOLDOFF_EN blocks further presses until every button is released.
module game_cmd_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_quit,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic [2:0] btn_level
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       w_raw;
  logic [2:0]       r_meta;
  logic [2:0]       r_sync;
  logic [2:0]       r_level;
  logic [2:0]       r_level_prev;
  logic [CNT_W-1:0] r_cnt [3];
  logic [2:0]       w_edge;
  logic [2:0]       w_press;
  logic [2:0]       w_cmd;
  logic [2:0]       r_cmd;

  // Bit order {quit, pause, start} matches btn_level.
  assign w_raw = {btn_quit, btn_pause, btn_start};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta       <= '0;
      r_sync       <= '0;
      r_level_prev <= '0;
    end else begin
      r_meta       <= w_raw;
      r_sync       <= r_meta;
      r_level_prev <= r_level;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_debounce
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_level[g] <= 1'b0;
        r_cnt[g]   <= '0;
      end else if (r_sync[g] == r_level[g]) begin
        r_cnt[g] <= '0;
      end else if (r_cnt[g] == CntMax) begin
        r_level[g] <= r_sync[g];
        r_cnt[g]   <= '0;
      end else begin
        r_cnt[g] <= r_cnt[g] + CNT_W'(1);
      end
    end
  end

  assign w_edge = r_level & ~r_level_prev;

`ifdef CMD_HOLDOFF_EN
  logic r_holdoff;

  assign w_press = w_edge & {3{~r_holdoff}};

  // Set on any issued command; only a cycle with all levels low clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_holdoff <= 1'b0;
    end else if (|w_press) begin
      r_holdoff <= 1'b1;
    end else if (r_level == 3'b000) begin
      r_holdoff <= 1'b0;
    end
  end
`else
  assign w_press = w_edge;
`endif

  // Priority quit > pause > start; simultaneous lower-priority presses are dropped.
  always_comb begin
    w_cmd = 3'b000;
    if (w_press[2]) begin
      w_cmd = 3'b010;
    end else if (w_press[1]) begin
      w_cmd = 3'b001;
    end else if (w_press[0]) begin
      w_cmd = 3'b100;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd <= 3'b000;
    end else begin
      r_cmd <= w_cmd;
    end
  end

  assign C         = r_cmd[2];
  assign D         = r_cmd[1];
  assign E         = r_cmd[0];
  assign btn_level = r_level;

endmodule

// File: tb/tb_game_cmd_encoder.sv
// Directed self-checking bench for game_cmd_encoder with DEBOUNCE_CYCLES=4.
// Holdoff expectations follow the CMD_HOLDOFF_EN build macro.
module tb_game_cmd_encoder;

  logic       clk;
  logic       reset;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_quit;
  logic       C;
  logic       D;
  logic       E;
  logic [2:0] btn_level;

  int n_cmp;
  int n_err;
  int n_c;
  int n_d;
  int n_e;
  int n_bad;
  logic [2:0] prev_code;

  game_cmd_encoder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .btn_quit (btn_quit),
    .C        (C),
    .D        (D),
    .E        (E),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, tallying single-cycle command pulses and any illegal/stretched code.
  task automatic step_n(input int n);
    logic [2:0] code;
    for (int i = 0; i < n; i++) begin
      tick();
      code = {C, D, E};
      case (code)
        3'b000: ;
        3'b100: n_c++;
        3'b010: n_d++;
        3'b001: n_e++;
        default: n_bad++;
      endcase
      if (code != 3'b000 && code == prev_code) n_bad++;
      prev_code = code;
    end
  endtask

  task automatic clear_tally();
    n_c = 0;
    n_d = 0;
    n_e = 0;
    n_bad = 0;
  endtask

  task automatic check_tally(input string tag, input int ec, input int ed, input int ee);
    check_val({tag, " C"}, n_c, ec);
    check_val({tag, " D"}, n_d, ed);
    check_val({tag, " E"}, n_e, ee);
    check_val({tag, " bad"}, n_bad, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    prev_code = 3'b000;
    clear_tally();
    reset = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_quit = 1'b0;

    // Reset state
    tick();
    tick();
    check_val("rst code", {C, D, E}, 3'b000);
    check_val("rst level", btn_level, 3'b000);
    reset = 1'b1;
    tick();

    // Start pressed before edge 0 and held: code 100 exactly after edge 6
    btn_start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("t1 code e%0d", k), {C, D, E}, (k == 6) ? 3'b100 : 3'b000);
      check_val($sformatf("t1 lvl e%0d", k), btn_level, (k >= 5) ? 3'b001 : 3'b000);
    end
    clear_tally();
    step_n(10);
    check_tally("t1 held", 0, 0, 0);

    // Release: level clears after edge 5, no code
    btn_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("rel code e%0d", k), {C, D, E}, 3'b000);
      check_val($sformatf("rel lvl e%0d", k), btn_level, (k >= 5) ? 3'b000 : 3'b001);
    end

    // Pause bouncing 3 high / 1 low is rejected, then steady high gives one pause
    clear_tally();
    for (int k = 0; k < 20; k++) begin
      btn_pause = ((k % 4) != 3);
      step_n(1);
    end
    check_tally("t2 bounce", 0, 0, 0);
    check_val("t2 bounce lvl", btn_level, 3'b000);
    btn_pause = 1'b1;
    step_n(12);
    check_tally("t2 steady", 0, 0, 1);
    check_val("t2 lvl", btn_level, 3'b010);
    btn_pause = 1'b0;
    step_n(10);
    check_val("t2 rel lvl", btn_level, 3'b000);

    // Quit and pause together: only quit
    clear_tally();
    btn_quit = 1'b1;
    btn_pause = 1'b1;
    step_n(12);
    check_tally("t3 both", 0, 1, 0);
    check_val("t3 lvl", btn_level, 3'b110);
    btn_quit = 1'b0;
    btn_pause = 1'b0;
    step_n(10);
    check_tally("t3 rel", 0, 1, 0);
    check_val("t3 rel lvl", btn_level, 3'b000);

    // Start held, pause pressed 10 cycles later
    clear_tally();
    btn_start = 1'b1;
    step_n(10);
    btn_pause = 1'b1;
    step_n(12);
`ifdef CMD_HOLDOFF_EN
    check_tally("t4 overlap", 1, 0, 0);
`else
    check_tally("t4 overlap", 1, 0, 1);
`endif
    btn_pause = 1'b0;
    step_n(8);
    btn_start = 1'b0;
    step_n(8);
    check_val("t4 all rel", btn_level, 3'b000);
    clear_tally();
    btn_pause = 1'b1;
    step_n(10);
    check_tally("t4 repress", 0, 0, 1);
    btn_pause = 1'b0;
    step_n(10);

    // Reset while start counter is at 2: immediate async clear, fresh debounce after
    btn_start = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b0;
    #1;
    check_val("t5 rst code", {C, D, E}, 3'b000);
    check_val("t5 rst lvl", btn_level, 3'b000);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("t5 code e%0d", k), {C, D, E}, (k == 6) ? 3'b100 : 3'b000);
    end

    // Reset during the command pulse clears the code at once
    btn_start = 1'b0;
    step_n(10);
    btn_start = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check_val("t5b pulse", {C, D, E}, 3'b100);
    reset = 1'b0;
    #1;
    check_val("t5b rst code", {C, D, E}, 3'b000);
    check_val("t5b rst lvl", btn_level, 3'b000);
    tick();
    reset = 1'b1;
    btn_start = 1'b0;
    clear_tally();
    step_n(12);
    check_tally("t5b after", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
